// File: rtl/led_sequencer.sv
// N-channel LED pattern generator (TOGGLE / CHASE / BOUNCE / BLINK_ALL) stepped by a prescaler.
// Optional macro LED_SEQ_STEP_EN adds a step_req input that forces an immediate step.
module led_sequencer #(
   parameter  int NUM_LEDS = 3,
   parameter  int TICK_DIV = 100000000,
   localparam int POS_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [1:0]          mode,
   input  logic                dir,
`ifdef LED_SEQ_STEP_EN
   input  logic                step_req,
`endif
   output logic [NUM_LEDS-1:0] leds,
   output logic                tick,
   output logic [POS_W-1:0]    pos
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
   localparam logic [POS_W-1:0] POS_MAX = POS_W'(NUM_LEDS - 1);
   localparam logic [POS_W-1:0] POS_ZERO = {POS_W{1'b0}};

   localparam logic [1:0] MODE_TOGGLE = 2'd0;
   localparam logic [1:0] MODE_CHASE  = 2'd1;
   localparam logic [1:0] MODE_BOUNCE = 2'd2;
   localparam logic [1:0] MODE_BLINK  = 2'd3;

   logic [CNT_W-1:0]    count_q, count_d;
   logic [NUM_LEDS-1:0] leds_q, leds_d;
   logic [POS_W-1:0]    pos_q, pos_d;
   logic [1:0]          mode_q, mode_d;
   logic                up_q, up_d;
   logic                tick_q, tick_d;

   logic                mode_chg_s;
   logic                step_hit_s;
   logic                step_s;
   logic [POS_W-1:0]    pos_inc_s, pos_dec_s, pos_nxt_s;
   logic [NUM_LEDS-1:0] onehot_s;

   assign mode_chg_s = (mode != mode_q);
`ifdef LED_SEQ_STEP_EN
   assign step_hit_s = step_req;
`else
   assign step_hit_s = 1'b0;
`endif
   assign step_s = en && !mode_chg_s && ((count_q == CNT_MAX) || step_hit_s);

   // Wrapping index arithmetic stays within 0..NUM_LEDS-1, including NUM_LEDS == 1.
   assign pos_inc_s = (pos_q == POS_MAX)  ? POS_ZERO : pos_q + POS_W'(1);
   assign pos_dec_s = (pos_q == POS_ZERO) ? POS_MAX  : pos_q - POS_W'(1);
   assign pos_nxt_s = dir ? pos_dec_s : pos_inc_s;
   assign onehot_s  = NUM_LEDS'(1'b1) << pos_q;

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= {CNT_W{1'b0}};
         leds_q  <= {NUM_LEDS{1'b0}};
         pos_q   <= POS_ZERO;
         mode_q  <= MODE_TOGGLE;
         up_q    <= 1'b1;
         tick_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         leds_q  <= leds_d;
         pos_q   <= pos_d;
         mode_q  <= mode_d;
         up_q    <= up_d;
         tick_q  <= tick_d;
      end
   end

   // Next-state: mode change restarts the pattern, otherwise prescaler and step action.
   always_comb begin
      count_d = count_q;
      leds_d  = leds_q;
      pos_d   = pos_q;
      mode_d  = mode_q;
      up_d    = up_q;
      tick_d  = 1'b0;
      if (mode_chg_s) begin
         mode_d  = mode;
         count_d = {CNT_W{1'b0}};
         leds_d  = {NUM_LEDS{1'b0}};
         pos_d   = POS_ZERO;
         up_d    = 1'b1;
      end else if (step_s) begin
         count_d = {CNT_W{1'b0}};
         tick_d  = 1'b1;
         case (mode_q)
            MODE_TOGGLE: begin
               leds_d = leds_q ^ onehot_s;
               pos_d  = pos_nxt_s;
            end
            MODE_CHASE: begin
               leds_d = onehot_s;
               pos_d  = pos_nxt_s;
            end
            MODE_BOUNCE: begin
               leds_d = onehot_s;
               if (up_q) begin
                  if (pos_q == POS_MAX) begin
                     up_d  = 1'b0;
                     pos_d = pos_dec_s;
                  end else begin
                     pos_d = pos_inc_s;
                  end
               end else begin
                  if (pos_q == POS_ZERO) begin
                     up_d  = 1'b1;
                     pos_d = pos_inc_s;
                  end else begin
                     pos_d = pos_dec_s;
                  end
               end
            end
            MODE_BLINK: begin
               leds_d = ~leds_q;
            end
            default: begin
               leds_d = leds_q;
               pos_d  = pos_q;
            end
         endcase
      end else if (en) begin
         count_d = count_q + CNT_W'(1);
      end else begin
         count_d = count_q;
      end
   end

   // Outputs come straight from registers.
   always_comb begin
      leds = leds_q;
      tick = tick_q;
      pos  = pos_q;
   end

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer: directed test-plan scenarios plus randomized
// stimulus against a behavioural model (3-LED and 4-LED instances, TICK_DIV=4).
module tb_led_sequencer;

   localparam int TDIV = 4;

   logic       clk;
   logic       rst;
   logic       en;
   logic [1:0] mode;
   logic       dir;
`ifdef LED_SEQ_STEP_EN
   logic       step_req;
`endif
   logic [2:0] leds3;
   logic       tick3;
   logic [1:0] pos3;
   logic [3:0] leds4;
   logic       tick4;
   logic [1:0] pos4;

   int n_cmp = 0;
   int n_bad = 0;

   // Model state per instance: index 0 = 3 LEDs, index 1 = 4 LEDs.
   int          m_n   [2] = '{3, 4};
   int          m_cnt [2];
   int          m_pos [2];
   int          m_mq  [2];
   bit          m_up  [2];
   bit          m_tick[2];
   logic [31:0] m_leds[2];

   logic [2:0] t1_leds [6] = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b100, 3'b000};
   int         t1_pos  [6] = '{1, 2, 0, 1, 2, 0};
   logic [2:0] t2_leds [6] = '{3'b001, 3'b100, 3'b010, 3'b001, 3'b100, 3'b001};
   int         t2_pos  [6] = '{2, 1, 0, 2, 0, 1};
   logic [3:0] t3_leds [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                               4'b0100, 4'b0010, 4'b0001, 4'b0010};

   led_sequencer #(.NUM_LEDS(3), .TICK_DIV(TDIV)) dut3 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir),
`ifdef LED_SEQ_STEP_EN
      .step_req(step_req),
`endif
      .leds(leds3), .tick(tick3), .pos(pos3)
   );

   led_sequencer #(.NUM_LEDS(4), .TICK_DIV(TDIV)) dut4 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir),
`ifdef LED_SEQ_STEP_EN
      .step_req(step_req),
`endif
      .leds(leds4), .tick(tick4), .pos(pos4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference behaviour written directly from the pattern rules, using modular arithmetic.
   task automatic model_edge();
      bit sreq;
      sreq = 1'b0;
`ifdef LED_SEQ_STEP_EN
      sreq = step_req;
`endif
      for (int k = 0; k < 2; k++) begin
         int n;
         logic [31:0] mask;
         n    = m_n[k];
         mask = (32'd1 << n) - 32'd1;
         if (rst) begin
            m_cnt[k] = 0; m_pos[k] = 0; m_mq[k] = 0; m_up[k] = 1'b1;
            m_tick[k] = 1'b0; m_leds[k] = 32'd0;
         end else if (int'(mode) != m_mq[k]) begin
            m_mq[k] = int'(mode); m_cnt[k] = 0; m_pos[k] = 0; m_up[k] = 1'b1;
            m_tick[k] = 1'b0; m_leds[k] = 32'd0;
         end else if (!en) begin
            m_tick[k] = 1'b0;
         end else if (m_cnt[k] == TDIV - 1 || sreq) begin
            m_cnt[k]  = 0;
            m_tick[k] = 1'b1;
            case (m_mq[k])
               0: begin
                  m_leds[k] = m_leds[k] ^ (32'd1 << m_pos[k]);
                  m_pos[k]  = dir ? (m_pos[k] + n - 1) % n : (m_pos[k] + 1) % n;
               end
               1: begin
                  m_leds[k] = 32'd1 << m_pos[k];
                  m_pos[k]  = dir ? (m_pos[k] + n - 1) % n : (m_pos[k] + 1) % n;
               end
               2: begin
                  m_leds[k] = 32'd1 << m_pos[k];
                  if (m_up[k]) begin
                     if (m_pos[k] == n - 1) begin
                        m_up[k] = 1'b0; m_pos[k] = (m_pos[k] > 0) ? m_pos[k] - 1 : 0;
                     end else m_pos[k] = m_pos[k] + 1;
                  end else begin
                     if (m_pos[k] == 0) begin
                        m_up[k] = 1'b1; m_pos[k] = (n > 1) ? 1 : 0;
                     end else m_pos[k] = m_pos[k] - 1;
                  end
               end
               default: m_leds[k] = ~m_leds[k] & mask;
            endcase
         end else begin
            m_cnt[k]  = m_cnt[k] + 1;
            m_tick[k] = 1'b0;
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic apply_reset(input logic [1:0] md);
      rst = 1'b1; en = 1'b1; mode = md; dir = 1'b0;
`ifdef LED_SEQ_STEP_EN
      step_req = 1'b0;
`endif
      repeat (2) cycle();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset(2'd0);
      n_cmp++;
      if (leds3 !== 3'b000 || tick3 !== 1'b0 || pos3 !== 2'd0) begin
         n_bad++;
         $display("FAIL reset3: leds=%b tick=%b pos=%0d, need 000/0/0", leds3, tick3, pos3);
      end
      n_cmp++;
      if (leds4 !== 4'b0000 || tick4 !== 1'b0 || pos4 !== 2'd0) begin
         n_bad++;
         $display("FAIL reset4: leds=%b tick=%b pos=%0d, need 0000/0/0", leds4, tick4, pos4);
      end
   endtask

   task automatic test_toggle();
      apply_reset(2'd0);
      for (int k = 1; k <= 24; k++) begin
         cycle();
         n_cmp++;
         if (tick3 !== (k % 4 == 0)) begin
            n_bad++;
            $display("FAIL toggle_tick edge %0d: got %b need %b", k, tick3, (k % 4 == 0));
         end
         if (k % 4 == 0) begin
            n_cmp++;
            if (leds3 !== t1_leds[k/4-1] || int'(pos3) != t1_pos[k/4-1]) begin
               n_bad++;
               $display("FAIL toggle_step %0d: leds=%b pos=%0d need %b/%0d",
                        k/4, leds3, pos3, t1_leds[k/4-1], t1_pos[k/4-1]);
            end
         end
      end
   endtask

   task automatic test_chase();
      apply_reset(2'd1);
      dir = 1'b1;
      for (int k = 1; k <= 25; k++) begin
         bit exp_t;
         cycle();
         exp_t = (k >= 5) && ((k - 1) % 4 == 0);
         n_cmp++;
         if (tick3 !== exp_t) begin
            n_bad++;
            $display("FAIL chase_tick edge %0d: got %b need %b", k, tick3, exp_t);
         end
         if (exp_t) begin
            n_cmp++;
            if (leds3 !== t2_leds[(k-5)/4] || int'(pos3) != t2_pos[(k-5)/4]) begin
               n_bad++;
               $display("FAIL chase_step %0d: leds=%b pos=%0d need %b/%0d",
                        (k-5)/4, leds3, pos3, t2_leds[(k-5)/4], t2_pos[(k-5)/4]);
            end
         end
         if (k == 17) dir = 1'b0;
      end
   endtask

   task automatic test_bounce();
      apply_reset(2'd2);
      for (int k = 1; k <= 33; k++) begin
         bit exp_t;
         cycle();
         dir = 1'($urandom_range(0, 1));
         exp_t = (k >= 5) && ((k - 1) % 4 == 0);
         n_cmp++;
         if (tick4 !== exp_t) begin
            n_bad++;
            $display("FAIL bounce_tick edge %0d: got %b need %b", k, tick4, exp_t);
         end
         if (exp_t) begin
            n_cmp++;
            if (leds4 !== t3_leds[(k-5)/4]) begin
               n_bad++;
               $display("FAIL bounce_step %0d: leds=%b need %b", (k-5)/4, leds4, t3_leds[(k-5)/4]);
            end
         end
      end
   endtask

   task automatic test_blink_hold();
      logic [2:0] exp_l;
      apply_reset(2'd3);
      exp_l = 3'b000;
      for (int k = 1; k <= 13; k++) begin
         cycle();
         if (k >= 5 && (k - 1) % 4 == 0) begin
            exp_l = ~exp_l;
            n_cmp++;
            if (tick3 !== 1'b1 || leds3 !== exp_l) begin
               n_bad++;
               $display("FAIL blink_step edge %0d: tick=%b leds=%b need 1/%b", k, tick3, leds3, exp_l);
            end
         end
      end
      repeat (2) cycle();
      en = 1'b0;
      for (int k = 0; k < 10; k++) begin
         cycle();
         n_cmp++;
         if (tick3 !== 1'b0 || leds3 !== exp_l) begin
            n_bad++;
            $display("FAIL hold cycle %0d: tick=%b leds=%b need 0/%b", k, tick3, leds3, exp_l);
         end
      end
      en = 1'b1;
      cycle();
      n_cmp++;
      if (tick3 !== 1'b0) begin
         n_bad++;
         $display("FAIL resume_early: tick=%b need 0", tick3);
      end
      cycle();
      n_cmp++;
      if (tick3 !== 1'b1 || leds3 !== ~exp_l) begin
         n_bad++;
         $display("FAIL resume_step: tick=%b leds=%b need 1/%b", tick3, leds3, ~exp_l);
      end
   endtask

   task automatic test_mode_change_reset();
      apply_reset(2'd0);
      repeat (11) cycle();
      n_cmp++;
      if (leds3 !== 3'b011) begin
         n_bad++;
         $display("FAIL pre_switch: leds=%b need 011", leds3);
      end
      mode = 2'd1;
      cycle();
      n_cmp++;
      if (leds3 !== 3'b000 || pos3 !== 2'd0 || tick3 !== 1'b0) begin
         n_bad++;
         $display("FAIL mode_switch: leds=%b pos=%0d tick=%b need 000/0/0", leds3, pos3, tick3);
      end
      for (int k = 1; k <= 4; k++) begin
         cycle();
         n_cmp++;
         if (tick3 !== (k == 4) || (k == 4 && leds3 !== 3'b001)) begin
            n_bad++;
            $display("FAIL post_switch edge %0d: tick=%b leds=%b need %b/001", k, tick3, leds3, (k == 4));
         end
      end
      repeat (2) cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      n_cmp++;
      if (leds3 !== 3'b000 || tick3 !== 1'b0 || pos3 !== 2'd0) begin
         n_bad++;
         $display("FAIL mid_reset: leds=%b tick=%b pos=%0d need 000/0/0", leds3, tick3, pos3);
      end
   endtask

`ifdef LED_SEQ_STEP_EN
   task automatic test_step_req();
      bit         exp_t;
      logic [2:0] exp_l;
      apply_reset(2'd1);
      repeat (2) cycle();
      for (int k = 3; k <= 15; k++) begin
         step_req = (k == 3 || k == 11);
         cycle();
         step_req = 1'b0;
         exp_t = (k == 3 || k == 7 || k == 11 || k == 15);
         exp_l = (k == 7) ? 3'b010 : (k == 11) ? 3'b100 : 3'b001;
         n_cmp++;
         if (tick3 !== exp_t || (exp_t && leds3 !== exp_l)) begin
            n_bad++;
            $display("FAIL step_req edge %0d: tick=%b leds=%b need %b/%b", k, tick3, leds3, exp_t, exp_l);
         end
      end
   endtask
`endif

   task automatic test_random();
      apply_reset(2'd0);
      for (int k = 0; k < 800; k++) begin
         rst  = ($urandom_range(0, 63) == 0);
         en   = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
         dir  = 1'($urandom_range(0, 1));
`ifdef LED_SEQ_STEP_EN
         step_req = ($urandom_range(0, 7) == 0);
`endif
         cycle();
         n_cmp++;
         if (leds3 !== m_leds[0][2:0] || tick3 !== m_tick[0] || int'(pos3) != m_pos[0]) begin
            n_bad++;
            $display("FAIL random3 cyc %0d: leds=%b tick=%b pos=%0d need %b/%b/%0d",
                     k, leds3, tick3, pos3, m_leds[0][2:0], m_tick[0], m_pos[0]);
         end
         n_cmp++;
         if (leds4 !== m_leds[1][3:0] || tick4 !== m_tick[1] || int'(pos4) != m_pos[1]) begin
            n_bad++;
            $display("FAIL random4 cyc %0d: leds=%b tick=%b pos=%0d need %b/%b/%0d",
                     k, leds4, tick4, pos4, m_leds[1][3:0], m_tick[1], m_pos[1]);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; mode = 2'd0; dir = 1'b0;
`ifdef LED_SEQ_STEP_EN
      step_req = 1'b0;
`endif
      test_reset();
      test_toggle();
      test_chase();
      test_bounce();
      test_blink_hold();
      test_mode_change_reset();
`ifdef LED_SEQ_STEP_EN
      test_step_req();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
